// File: rtl/skid_buffer_pkg.sv
// Shared constants for the skid buffer: state encoding and default word width.
package skid_buffer_pkg;
  localparam int SKID_LENGTH = 32;

  localparam logic [1:0] SKID_EMPTY = 2'd0;
  localparam logic [1:0] SKID_ONE   = 2'd1;
  localparam logic [1:0] SKID_TWO   = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = SKID_EMPTY,
    ST_ONE   = SKID_ONE,
    ST_TWO   = SKID_TWO
  } skid_state_e;
endpackage

// File: rtl/skid_buffer_if.sv
// Upstream/downstream handshake bundle seen by the skid buffer.
interface skid_buffer_if #(parameter int LENGTH = 32);
  logic [LENGTH-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic [LENGTH-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              i_flush;

  modport slave (
    input  i_data, i_valid, i_ready, i_flush,
    output o_ready, o_data, o_valid
  );

  modport master (
    output i_data, i_valid, i_ready, i_flush,
    input  o_ready, o_data, o_valid
  );
endinterface

// File: rtl/skid_buffer_ctrl.sv
// Occupancy FSM and registered upstream ready; steers the two data registers.
module skid_buffer_ctrl
  import skid_buffer_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic up_valid,
  input  logic dn_ready,
  input  logic flush,
  output logic ready,
  output logic valid,
  output logic main_load,
  output logic main_sel_skid,
  output logic skid_load
);
  skid_state_e state, nxt;
  logic        ready_q;
  logic        in_fire, out_fire;

  assign valid    = (state != ST_EMPTY);
  assign ready    = ready_q;
  assign in_fire  = up_valid & ready_q;
  assign out_fire = valid & dn_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= nxt;
      ready_q <= (nxt != ST_TWO);
    end
  end

  always_comb begin
    nxt           = state;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    if (flush) begin
      // Squash drops everything, including a word handshaking this cycle.
      nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_fire) begin
          main_load = 1'b1;
          nxt       = ST_ONE;
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            nxt       = ST_TWO;
          end else if (out_fire) begin
            nxt = ST_EMPTY;
          end
        end
        ST_TWO: if (out_fire) begin
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
          nxt           = ST_ONE;
        end
        default: nxt = ST_EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready pipeline register; ready toward upstream is a flop.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int LENGTH = SKID_LENGTH
) (
  input logic          clk,
  input logic          resetn,
  skid_buffer_if.slave bus
);
  logic [LENGTH-1:0] main_q, skid_q;
  logic              main_load, main_sel_skid, skid_load;

  skid_buffer_ctrl u_ctrl (
    .clk           (clk),
    .resetn        (resetn),
    .up_valid      (bus.i_valid),
    .dn_ready      (bus.i_ready),
    .flush         (bus.i_flush),
    .ready         (bus.o_ready),
    .valid         (bus.o_valid),
    .main_load     (main_load),
    .main_sel_skid (main_sel_skid),
    .skid_load     (skid_load)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_load) main_q <= main_sel_skid ? skid_q : bus.i_data;
      if (skid_load) skid_q <= bus.i_data;
    end
  end

  assign bus.o_data = main_q;
endmodule
